// File: rtl/stack_op_sequencer_if.sv
// Command/response handshake bundle between a command source and stack_op_sequencer.
// rsp_flags exists only when STK_SEQ_FLAGS_EN is defined.
interface stack_op_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [1:0]       rsp_err;
`ifdef STK_SEQ_FLAGS_EN
  logic [1:0]       rsp_flags;

  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, rsp_flags
  );
`else
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
`endif
endinterface

// File: rtl/stack_op_sequencer.sv
// Stack-machine command sequencer driving a registered-output LIFO via push/pop/tos strobes.
// Optional STK_SEQ_FLAGS_EN adds {carry, zero} response flags.
module stack_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  stack_op_sequencer_if.slave    bus,
  output logic [$clog2(DEPTH):0] depth,
  output logic [WIDTH-1:0]       stk_in,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic                   stk_tos,
  input  logic [WIDTH-1:0]       stk_out
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] DEPTH_FULL = DW'(DEPTH);
  localparam logic [DW-1:0] ONE        = DW'(1);
  localparam logic [DW-1:0] TWO        = DW'(2);

  typedef enum logic [2:0] {
    IDLE,
    POP_A,
    POP_B,
    CALC,
    PUSH,
    READ,
    RESP
  } state_e;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_TOS  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_OR   = 3'd6,
    OP_NOT  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'b00,
    ERR_UNDER = 2'b01,
    ERR_OVER  = 2'b10
  } err_e;

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] opa;

  op_e              cmd_op_e;
  err_e             cmd_err;
  logic [WIDTH-1:0] alu_r;

  assign cmd_op_e = op_e'(bus.cmd_op);

  function automatic logic is_binary(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Errors are decided from the tracked depth alone, so a faulting command never strobes the stack.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cmd_err = ERR_OK;
    if (cmd_op_e == OP_PUSH) begin
      if (depth == DEPTH_FULL) cmd_err = ERR_OVER;
    end else if (is_binary(cmd_op_e)) begin
      if (depth < TWO) cmd_err = ERR_UNDER;
    end else begin
      if (depth == '0) cmd_err = ERR_UNDER;
    end
  end

  // In CALC, opa holds A (top of stack) and stk_out holds B (the deeper operand).
  always_comb begin
    alu_r = opa;
    unique case (op_q)
      OP_ADD:  alu_r = stk_out + opa;
      OP_SUB:  alu_r = stk_out - opa;
      OP_AND:  alu_r = stk_out & opa;
      OP_OR:   alu_r = stk_out | opa;
      OP_NOT:  alu_r = ~opa;
      default: alu_r = opa;
    endcase
  end

`ifdef STK_SEQ_FLAGS_EN
  logic             alu_c;
  logic             carry_q;
  logic [WIDTH:0]   sum_ext;

  always_comb begin
    sum_ext = {1'b0, stk_out} + {1'b0, opa};
    alu_c   = 1'b0;
    unique case (op_q)
      OP_ADD:  alu_c = sum_ext[WIDTH];
      OP_SUB:  alu_c = (stk_out < opa);
      default: alu_c = 1'b0;
    endcase
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only; the strobes default low each
  // cycle and are overridden below, which makes every strobe exactly one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      op_q          <= OP_PUSH;
      opa           <= '0;
      depth         <= '0;
      stk_in        <= '0;
      stk_push      <= 1'b0;
      stk_pop       <= 1'b0;
      stk_tos       <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= ERR_OK;
`ifdef STK_SEQ_FLAGS_EN
      bus.rsp_flags <= 2'b00;
      carry_q       <= 1'b0;
`endif
    end else begin
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_tos  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q          <= cmd_op_e;
            bus.cmd_ready <= 1'b0;
`ifdef STK_SEQ_FLAGS_EN
            carry_q       <= 1'b0;
`endif
            if (cmd_err != ERR_OK) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_data  <= '0;
              bus.rsp_err   <= cmd_err;
`ifdef STK_SEQ_FLAGS_EN
              bus.rsp_flags <= 2'b00;
`endif
            end else begin
              unique case (cmd_op_e)
                OP_PUSH: begin
                  stk_push <= 1'b1;
                  stk_in   <= bus.cmd_data;
                  depth    <= depth + ONE;
                  state    <= PUSH;
                end
                OP_TOS: begin
                  stk_tos <= 1'b1;
                  state   <= POP_A;
                end
                default: begin
                  stk_pop <= 1'b1;
                  depth   <= depth - ONE;
                  state   <= POP_A;
                end
              endcase
            end
          end
        end

        // First strobe is in flight; binary ops fire the second pop right behind it.
        POP_A: begin
          if (is_binary(op_q)) begin
            stk_pop <= 1'b1;
            depth   <= depth - ONE;
            state   <= POP_B;
          end else begin
            state <= READ;
          end
        end

        POP_B: begin
          opa   <= stk_out;
          state <= CALC;
        end

        READ: begin
          if (op_q == OP_NOT) begin
            opa   <= stk_out;
            state <= CALC;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= stk_out;
            bus.rsp_err   <= ERR_OK;
`ifdef STK_SEQ_FLAGS_EN
            bus.rsp_flags <= {1'b0, (stk_out == '0)};
`endif
            state         <= RESP;
          end
        end

        CALC: begin
          stk_push <= 1'b1;
          stk_in   <= alu_r;
          depth    <= depth + ONE;
`ifdef STK_SEQ_FLAGS_EN
          carry_q  <= alu_c;
`endif
          state    <= PUSH;
        end

        // stk_in still holds the value being pushed, which is also the response payload.
        PUSH: begin
          bus.rsp_valid <= 1'b1;
          bus.rsp_data  <= stk_in;
          bus.rsp_err   <= ERR_OK;
`ifdef STK_SEQ_FLAGS_EN
          bus.rsp_flags <= {carry_q, (stk_in == '0)};
`endif
          state         <= RESP;
        end

        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.cmd_ready <= 1'b1;
            state         <= IDLE;
          end
        end

        default: begin
          bus.rsp_valid <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  a_one_strobe : assert property (@(posedge clk) disable iff (rst)
    $onehot0({stk_push, stk_pop, stk_tos}));

  a_depth_bound : assert property (@(posedge clk) disable iff (rst)
    depth <= DEPTH_FULL);

  a_rsp_hold : assert property (@(posedge clk) disable iff (rst)
    (bus.rsp_valid && !bus.rsp_ready) |=>
      (bus.rsp_valid && $stable(bus.rsp_data) && $stable(bus.rsp_err)));

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Directed bench for stack_op_sequencer: behavioural LIFO on the stack side, reference
// model feeding a response scoreboard. Honors STK_SEQ_FLAGS_EN when defined.
module tb_stack_op_sequencer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 32;
  localparam int DW    = $clog2(DEPTH) + 1;

  localparam logic [2:0] C_PUSH = 3'd0, C_POP = 3'd1, C_TOS = 3'd2, C_ADD = 3'd3,
                         C_SUB  = 3'd4, C_AND = 3'd5, C_OR  = 3'd6, C_NOT = 3'd7;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [1:0]       err;
    int               depth;
    int               lat;
    logic [1:0]       flags;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  logic [DW-1:0]    depth;
  logic [WIDTH-1:0] stk_in;
  logic [WIDTH-1:0] stk_out;
  logic             stk_push;
  logic             stk_pop;
  logic             stk_tos;

  stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .depth    (depth),
    .stk_in   (stk_in),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_tos  (stk_tos),
    .stk_out  (stk_out)
  );

  // Behavioural LIFO with registered output, sharing rst with the sequencer.
  logic [WIDTH-1:0] mem [DEPTH];
  int sp;
  int stk_violations = 0;
  int push_cnt = 0;
  int pop_cnt  = 0;
  int tos_cnt  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= 0;
      stk_out <= '0;
    end else begin
      if (int'(stk_push) + int'(stk_pop) + int'(stk_tos) > 1) stk_violations <= stk_violations + 1;
      if (stk_push) begin
        push_cnt <= push_cnt + 1;
        if (sp >= DEPTH) stk_violations <= stk_violations + 1;
        else begin
          mem[sp] <= stk_in;
          sp      <= sp + 1;
        end
      end else if (stk_pop) begin
        pop_cnt <= pop_cnt + 1;
        if (sp == 0) stk_violations <= stk_violations + 1;
        else begin
          stk_out <= mem[sp-1];
          sp      <= sp - 1;
        end
      end else if (stk_tos) begin
        tos_cnt <= tos_cnt + 1;
        if (sp == 0) stk_violations <= stk_violations + 1;
        else stk_out <= mem[sp-1];
      end
    end
  end

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] model [$];
  exp_t sb [$];
  string op_name [8] = '{"PUSH", "POP", "TOS", "ADD", "SUB", "AND", "OR", "NOT"};

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_step(input logic [2:0] op, input logic [WIDTH-1:0] d, output exp_t e);
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   s;
    logic             carry;
    int n = model.size();
    e.data = '0; e.err = 2'b00; carry = 1'b0;
    case (op)
      C_PUSH: if (n == DEPTH) e.err = 2'b10;
              else begin model.push_back(d); e.data = d; end
      C_POP:  if (n == 0) e.err = 2'b01; else e.data = model.pop_back();
      C_TOS:  if (n == 0) e.err = 2'b01; else e.data = model[n-1];
      C_NOT:  if (n == 0) e.err = 2'b01;
              else begin a = model.pop_back(); e.data = ~a; model.push_back(e.data); end
      default: if (n < 2) e.err = 2'b01;
               else begin
                 a = model.pop_back();
                 b = model.pop_back();
                 case (op)
                   C_ADD: begin s = {1'b0, b} + {1'b0, a}; e.data = s[WIDTH-1:0]; carry = s[WIDTH]; end
                   C_SUB: begin e.data = b - a; carry = (b < a); end
                   C_AND: e.data = b & a;
                   default: e.data = b | a;
                 endcase
                 model.push_back(e.data);
               end
    endcase
    if (e.err != 2'b00)                     e.lat = 1;
    else if (op == C_PUSH)                  e.lat = 2;
    else if (op == C_POP || op == C_TOS)    e.lat = 3;
    else                                    e.lat = 5;
    e.flags = {carry, (e.err == 2'b00) && (e.data == '0)};
    e.depth = model.size();
  endtask

  // Issue one command from a negedge, check the response, and return at the negedge
  // where the sequencer is back in IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] d, input int hold);
    exp_t e, got;
    int lat;
    string tag;
    tag = $sformatf("%s(0x%0h)", op_name[op], d);
    model_step(op, d, e);
    sb.push_back(e);
    check({tag, " cmd_ready"}, bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    bus.rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = sb.pop_front();
    check({tag, " latency"}, lat, got.lat);
    check({tag, " rsp_data"}, bus.rsp_data, got.data);
    check({tag, " rsp_err"}, bus.rsp_err, got.err);
    check({tag, " depth"}, depth, got.depth);
`ifdef STK_SEQ_FLAGS_EN
    check({tag, " rsp_flags"}, bus.rsp_flags, got.flags);
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s hold%0d rsp_valid", tag, i), bus.rsp_valid, 1);
      check($sformatf("%s hold%0d rsp_data", tag, i), bus.rsp_data, got.data);
      check($sformatf("%s hold%0d cmd_ready", tag, i), bus.cmd_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check({tag, " rsp_valid drop"}, bus.rsp_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rsp_valid"}, bus.rsp_valid, 0);
    check({tag, " rsp_data"}, bus.rsp_data, 0);
    check({tag, " rsp_err"}, bus.rsp_err, 0);
    check({tag, " depth"}, depth, 0);
    check({tag, " strobes"}, {stk_push, stk_pop, stk_tos}, 0);
    check({tag, " stk_in"}, stk_in, 0);
    check({tag, " cmd_ready"}, bus.cmd_ready, 1);
`ifdef STK_SEQ_FLAGS_EN
    check({tag, " rsp_flags"}, bus.rsp_flags, 0);
`endif
  endtask

  initial begin
    int p0, q0, t0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Subtraction: B (deeper) minus A, two pops and three pushes in total.
    p0 = push_cnt; q0 = pop_cnt;
    run_cmd(C_PUSH, 8'h05, 0);
    run_cmd(C_PUSH, 8'h03, 0);
    run_cmd(C_SUB, 8'h00, 0);
    check("sub pop strobes", pop_cnt - q0, 2);
    check("sub push strobes", push_cnt - p0, 3);
    run_cmd(C_POP, 8'h00, 0);

    // Wrapping add with carry out.
    run_cmd(C_PUSH, 8'hF0, 0);
    run_cmd(C_PUSH, 8'h20, 0);
    run_cmd(C_ADD, 8'h00, 0);
    run_cmd(C_POP, 8'h00, 0);

    // Underflow on empty stack, and a binary op with only one operand.
    p0 = push_cnt; q0 = pop_cnt; t0 = tos_cnt;
    run_cmd(C_POP, 8'h00, 0);
    check("empty pop strobes", (push_cnt - p0) + (pop_cnt - q0) + (tos_cnt - t0), 0);
    run_cmd(C_PUSH, 8'h07, 0);
    q0 = pop_cnt;
    run_cmd(C_ADD, 8'h00, 0);
    check("short add pops", pop_cnt - q0, 0);
    run_cmd(C_OR, 8'h00, 0);
    run_cmd(C_POP, 8'h00, 0);

    // Fill to capacity, overflow, peek, then drain.
    for (int i = 0; i < DEPTH; i++) run_cmd(C_PUSH, 8'(i), 0);
    p0 = push_cnt;
    run_cmd(C_PUSH, 8'hAA, 0);
    check("overflow push strobes", push_cnt - p0, 0);
    run_cmd(C_TOS, 8'h00, 0);
    for (int i = 0; i < DEPTH; i++) run_cmd(C_POP, 8'h00, 0);
    run_cmd(C_TOS, 8'h00, 0);

    // Remaining ALU ops, including a zero result.
    run_cmd(C_PUSH, 8'hCC, 0);
    run_cmd(C_PUSH, 8'h0F, 0);
    run_cmd(C_AND, 8'h00, 0);
    run_cmd(C_PUSH, 8'h30, 0);
    run_cmd(C_OR, 8'h00, 0);
    run_cmd(C_PUSH, 8'h3C, 0);
    run_cmd(C_SUB, 8'h00, 0);
    run_cmd(C_PUSH, 8'h01, 0);
    run_cmd(C_SUB, 8'h00, 0);
    run_cmd(C_POP, 8'h00, 0);

    // Inversion with a stalled response.
    run_cmd(C_PUSH, 8'h5A, 0);
    run_cmd(C_NOT, 8'h00, 4);
    run_cmd(C_POP, 8'h00, 0);

    // Reset while the second pop of an ADD is on the strobe.
    run_cmd(C_PUSH, 8'h01, 0);
    run_cmd(C_PUSH, 8'h02, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = C_ADD;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("pop_b strobe", stk_pop, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid-cmd reset");
    model.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(C_PUSH, 8'h11, 0);
    run_cmd(C_POP, 8'h00, 0);

    check("stack protocol violations", stk_violations, 0);
    check("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
